mul_seq_controller: RTL and testbench

//   Sequencing FSM for the CA1 shift-add multiplier datapath. Accepts a start request,

---
 rtl/mul_seq_controller_pkg.sv | 26 ++
 rtl/iter_counter.sv | 26 ++
 rtl/mul_seq_controller.sv | 91 +++++++++
 tb/tb_mul_seq_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_controller_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: state encoding,
// default counter parameters and the decoded control-output bundle.
package mul_seq_controller_pkg;

  localparam int CNT_W_DEF    = 4;
  localparam int LOAD_VAL_DEF = 2;
  localparam int TERM_VAL_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic init;
    logic add;
    logic shift;
    logic done;
  } ctrl_t;

endpackage

// File: rtl/iter_counter.sv
// Loadable iteration counter for the multiplier sequencer.
// Priority: async clear > sync clear > load > count enable.
module iter_counter #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 2,
  parameter int TERM_VAL = 15
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr_sync,
  input  logic             load,
  input  logic             en,
  output logic             co,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)        cnt <= '0;
    else if (clr_sync) cnt <= '0;
    else if (load)     cnt <= CNT_W'(LOAD_VAL);
    else if (en)       cnt <= cnt + CNT_W'(1);
  end

  assign co = (cnt == CNT_W'(TERM_VAL));

endmodule

// File: rtl/mul_seq_controller.sv
// Sequencing FSM for the shift-add multiplier: INIT, then ADD/SHIFT pairs until
// the iteration counter reaches its terminal count, then a one-cycle done pulse.
module mul_seq_controller
  import mul_seq_controller_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOAD_VAL = LOAD_VAL_DEF,
  parameter int TERM_VAL = TERM_VAL_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             lsb,
  output logic             ready,
  output logic             busy,
  output logic             init,
  output logic             add,
  output logic             shift,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  state_t state, state_nxt;
  ctrl_t  ctl;
  logic   co;
  logic   abort_act;

  // abort is inert in IDLE, so a simultaneous start still launches a run
  assign abort_act = abort && (state != ST_IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctl       = '0;
    case (state)
      ST_IDLE: begin
        ctl.ready = 1'b1;
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        ctl.busy  = 1'b1;
        ctl.init  = 1'b1;
        state_nxt = ST_ADD;
      end
      ST_ADD: begin
        ctl.busy  = 1'b1;
        ctl.add   = lsb;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ctl.busy  = 1'b1;
        ctl.shift = 1'b1;
        state_nxt = co ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        ctl.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_act) state_nxt = ST_IDLE;
  end

  // Counter holds at terminal count on the final SHIFT rather than wrapping
  iter_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (LOAD_VAL),
    .TERM_VAL (TERM_VAL)
  ) u_cnt (
    .clk      (clk),
    .clr_n    (clr_n),
    .clr_sync (abort_act),
    .load     (state == ST_INIT),
    .en       ((state == ST_SHIFT) && !co),
    .co       (co),
    .cnt      (cnt)
  );

  assign ready = ctl.ready;
  assign busy  = ctl.busy;
  assign init  = ctl.init;
  assign add   = ctl.add;
  assign shift = ctl.shift;
  assign done  = ctl.done;

endmodule

// File: tb/tb_mul_seq_controller.sv
// Scoreboard bench for mul_seq_controller: stimulus queues expected run results
// and state snapshots, a negedge monitor pops and compares them.
module tb_mul_seq_controller;

  logic       clk = 1'b0;
  logic       clr_n, start0, start1, abort, lsb;
  logic       rdy[2], bsy[2], ini[2], ad[2], sh[2], dn[2];
  logic [3:0] cnt_o[2];

  always #5 clk = ~clk;

  mul_seq_controller dut0 (
    .clk(clk), .clr_n(clr_n), .start(start0), .abort(abort), .lsb(lsb),
    .ready(rdy[0]), .busy(bsy[0]), .init(ini[0]), .add(ad[0]),
    .shift(sh[0]), .done(dn[0]), .cnt(cnt_o[0])
  );

  mul_seq_controller #(.CNT_W(4), .LOAD_VAL(13), .TERM_VAL(15)) dut1 (
    .clk(clk), .clr_n(clr_n), .start(start1), .abort(abort), .lsb(lsb),
    .ready(rdy[1]), .busy(bsy[1]), .init(ini[1]), .add(ad[1]),
    .shift(sh[1]), .done(dn[1]), .cnt(cnt_o[1])
  );

  typedef struct {
    int dut; int lat; int adds; int shifts; int cnt; int gap;
  } run_t;
  typedef struct {
    logic r; logic b; logic d; logic [3:0] c; string name;
  } snap_t;

  run_t  exp_q[$];
  snap_t snap_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    finish_req = 1'b0;

  function void cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: the only process that compares and counts
  initial begin : monitor
    int    cyc;
    int    init_cyc[2], adds[2], shifts[2], last_done[2];
    bit    prev_dn[2], chk_rdy[2];
    run_t  e;
    snap_t s;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      init_cyc[d] = 0; adds[d] = 0; shifts[d] = 0; last_done[d] = 0;
      prev_dn[d] = 1'b0; chk_rdy[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        cmp({s.name, "_ready"}, int'(rdy[0]), int'(s.r));
        cmp({s.name, "_busy"},  int'(bsy[0]), int'(s.b));
        cmp({s.name, "_done"},  int'(dn[0]),  int'(s.d));
        cmp({s.name, "_cnt"},   int'(cnt_o[0]), int'(s.c));
      end
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("onehot%0d", d), int'(rdy[d]) + int'(bsy[d]) + int'(dn[d]), 1);
        if (chk_rdy[d]) begin
          cmp($sformatf("ready_after_done%0d", d), int'(rdy[d]), 1);
          chk_rdy[d] = 1'b0;
        end
        if (dn[d]) cmp($sformatf("done_single%0d", d), int'(prev_dn[d]), 0);
        prev_dn[d] = dn[d];
        if (ini[d]) begin
          init_cyc[d] = cyc; adds[d] = 0; shifts[d] = 0;
        end
        if (ad[d]) adds[d]++;
        if (sh[d]) shifts[d]++;
        if (dn[d]) begin
          if (exp_q.size() == 0) begin
            cmp($sformatf("unexpected_done%0d", d), int'(dn[d]), 0);
          end else begin
            e = exp_q.pop_front();
            cmp("run_dut", d, e.dut);
            cmp("run_latency", cyc - init_cyc[d] + 1, e.lat);
            cmp("run_adds", adds[d], e.adds);
            cmp("run_shifts", shifts[d], e.shifts);
            cmp("run_cnt", int'(cnt_o[d]), e.cnt);
            if (e.gap > 0) cmp("done_gap", cyc - last_done[d], e.gap);
          end
          last_done[d] = cyc;
          chk_rdy[d]   = 1'b1;
        end
      end
      if (cyc > 5000) begin
        cmp("watchdog_cycles", cyc, 5000);
        finish_req = 1'b1;
      end
      if (finish_req) begin
        cmp("pending_runs", exp_q.size(), 0);
        cmp("pending_snaps", snap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int d, input int lat, input int adds,
                          input int shifts, input int cnt, input int gap);
    run_t r;
    r.dut = d; r.lat = lat; r.adds = adds; r.shifts = shifts; r.cnt = cnt; r.gap = gap;
    exp_q.push_back(r);
  endtask

  task automatic push_snap(input logic r, input logic b, input logic d,
                           input logic [3:0] c, input string name);
    snap_t s;
    s.r = r; s.b = b; s.d = d; s.c = c; s.name = name;
    snap_q.push_back(s);
  endtask

  // Cycle 0 is the first driven cycle; start is held for cycles < hold.
  // alt=1 gives lsb=1 on the 1st, 3rd, 5th... ADD cycle (ADD cycles are 2,4,6...).
  task automatic drive(input int d, input int ncyc, input int hold, input bit alt);
    for (int c = 0; c < ncyc; c++) begin
      start0 = (d == 0) && (c < hold);
      start1 = (d == 1) && (c < hold);
      lsb    = alt ? (((c / 2) % 2) == 1) : 1'b1;
      step();
    end
    start0 = 1'b0;
    start1 = 1'b0;
    lsb    = 1'b0;
  endtask

  initial begin : stim
    clr_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; lsb = 1'b0;
    step();
    step();
    push_snap(1'b1, 1'b0, 1'b0, 4'd0, "reset");
    step();
    clr_n = 1'b1;
    step();

    // full run, lsb=1: 14 adds, 14 shifts, done 30 cycles after start
    push_run(0, 30, 14, 14, 15, 0);
    drive(0, 34, 1, 1'b0);

    // lsb alternating per iteration: 7 adds
    push_run(0, 30, 7, 14, 15, 0);
    drive(0, 34, 1, 1'b1);

    // start held: three back-to-back runs, dones 31 cycles apart
    push_run(0, 30, 14, 14, 15, 0);
    push_run(0, 30, 14, 14, 15, 31);
    push_run(0, 30, 14, 14, 15, 31);
    drive(0, 96, 93, 1'b0);

    // async reset during SHIFT of iteration with cnt=4 (cycle 7)
    drive(0, 7, 1, 1'b0);
    push_snap(1'b0, 1'b1, 1'b0, 4'd4, "mid_shift");
    @(negedge clk);
    #1;
    clr_n = 1'b0;
    push_snap(1'b1, 1'b0, 1'b0, 4'd0, "reset_mid");
    step();
    clr_n = 1'b1;
    drive(0, 3, 0, 1'b0);

    // abort in 5th ADD (cycle 10, cnt=6), then a fresh full run
    drive(0, 10, 1, 1'b0);
    lsb = 1'b1;
    push_snap(1'b0, 1'b1, 1'b0, 4'd6, "abort_add");
    abort = 1'b1;
    step();
    abort = 1'b0;
    push_snap(1'b1, 1'b0, 1'b0, 4'd0, "abort_idle");
    drive(0, 3, 0, 1'b0);
    push_run(0, 30, 14, 14, 15, 0);
    drive(0, 34, 1, 1'b0);

    // start and abort together in IDLE: start wins
    push_run(0, 30, 14, 14, 15, 0);
    start0 = 1'b1; abort = 1'b1; lsb = 1'b1;
    step();
    start0 = 1'b0; abort = 1'b0;
    drive(0, 33, 0, 1'b0);

    // LOAD_VAL=13, TERM_VAL=15: 3 iterations, done at cycle 8
    push_run(1, 8, 3, 3, 15, 0);
    drive(1, 12, 1, 1'b0);

    step();
    finish_req = 1'b1;
    step();
    step();
  end

endmodule
